shared_reg_arbiter: RTL
=======================

// Module: shared_reg_arbiter
// PURPOSE
//  - Round-robin arbiter and load sequencer for one shared WIDTH-bit enable register (DFF_EN-style storage).
//  - Grants up to NREQ requesters exclusive write access; drives the register load-enable and data mux internally.
//  - Returns a one-cycle ack to the requester whose data was written.
//  - Sits between requesting blocks and the shared register; q is the register's value, visible to all.
// PARAMETERS
//  - NREQ   4  number of requesters (2..8)
//  - WIDTH  8  width of the shared register and of each requester data word
// PORTS
//  - clk      in   1           system clock, all state updates on rising edge
//  - reset    in   1           asynchronous, active-low reset (0 = reset asserted)
//  - req      in   NREQ        write request per requester; held high until ack or abandoned
//  - data_in  in   NREQ*WIDTH  requester data; slice i = data_in[i*WIDTH +: WIDTH]
//  - gnt      out  NREQ        one-hot grant, registered; requester must hold data stable while granted
//  - ack      out  NREQ        one-hot, one-cycle pulse: write of that requester's data completed
//  - q        out  WIDTH       shared register contents
//  - busy     out  1           high whenever FSM is not IDLE
// BEHAVIOUR
//  - Reset (reset=0, immediate, no clock needed): state=IDLE, q=0, gnt=0, ack=0, busy=0, rr pointer=NREQ-1.
//  - FSM states: IDLE, GRANT, ACK (2-bit encoding).
//  - IDLE: if req!=0, pick winner w; gnt<=onehot(w), ptr<=w, state<=GRANT. Else stay; gnt=0.
//  - GRANT: if req[w]=1, q<=data_in slice w (register enable high this cycle only), ack<=onehot(w),
//    gnt<=0, state<=ACK. If req[w]=0 (abandoned): no write, no ack, gnt<=0, state<=IDLE.
//  - ACK: ack<=0, state<=IDLE unconditionally; requests seen only in IDLE.
//  - Latency: req high at edge E0 (state IDLE) -> gnt after E0 -> q and ack after E1 -> IDLE after E2.
//  - Throughput: one write per 3 cycles max; q changes only on a GRANT->ACK transition.
//  - Round-robin: search starts at index (ptr+1) mod NREQ, wraps past NREQ-1 to 0; first set req wins.
//  - ptr updated only at grant; abandoned grant still advances ptr.
//  - req changes from non-winners during GRANT/ACK: ignored, no effect on current transaction.
//  - Reset mid-transaction: transaction discarded, outputs to reset values at once, no ack.
//  - gnt and ack never both nonzero in the same cycle; at most one bit of each set.
// CONFIGURATION
//  - Macro ARB_FIXED_PRIO_EN.
//  - Defined: fixed priority, lowest-index requesting line always wins; rr pointer logic not built.
//  - Not defined (default): round-robin as above.
//  - Ports and FSM timing identical in both builds.
// STRUCTURE
//  - Shared package shared_arb_pkg: state encodings ST_IDLE=2'b00, ST_GRANT=2'b01, ST_ACK=2'b10,
//    plus a onehot-of-index function.
//  - One sub-module rr_pick: combinational, inputs req and ptr, outputs winner index and valid.
//    Fixed-priority build reduces to a priority encoder.
//  - Top holds the FSM, the winner/ptr registers, the data mux and the WIDTH-bit enable register.
// TESTING (NREQ=4, WIDTH=8, 20 ns clock)
//  - Reset: reset=0 during GRANT -> q=8'h00, gnt=4'b0000, ack=0, busy=0 immediately; first grant after release goes to req0.
//  - Single write: req=4'b0010, slice1=8'hA5 -> gnt=4'b0010 after E0; q=8'hA5 and ack=4'b0010 after E1; busy low after E2.
//  - Fairness: req=4'b1111 held, distinct data -> grant order 0,1,2,3,0, one grant every 3 cycles; q tracks each winner's data.
//  - Abandon: req2 alone, drop req2 during GRANT -> q unchanged, no ack, IDLE next cycle; next grant search starts at 3.
//  - Wrap: ptr=3, req=4'b1001 -> req0 wins, then req3.
//  - Macro: with ARB_FIXED_PRIO_EN, req=4'b1111 held -> req0 granted every time; req=4'b1100 -> req2 granted every time.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types for the shared-register arbiter: FSM state encoding, requester index type
// and a one-hot helper. Imported by the arbiter top and by rr_pick.
package shared_arb_pkg;

  localparam int MAX_NREQ = 8;
  localparam int IDX_W    = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_ACK   = 2'b10
  } state_t;

  function automatic logic [MAX_NREQ-1:0] onehot(input idx_t idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests and data in,
// grant/ack/register value/busy out.
interface shared_reg_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  busy;

  modport master (
    output req, data_in,
    input  gnt, ack, q, busy
  );

  modport slave (
    input  req, data_in,
    output gnt, ack, q, busy
  );
endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational winner selection. Round-robin from ptr+1 by default; with
// ARB_FIXED_PRIO_EN defined it is a plain lowest-index priority encoder and ptr is absent.
module rr_pick
  import shared_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
`ifndef ARB_FIXED_PRIO_EN
  input  idx_t            ptr,
`endif
  output idx_t            winner,
  output logic            valid
);

`ifdef ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest set index is the last (winning) assignment.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = idx_t'(i);
        valid  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // The last winner gets the lowest priority: start one past it and wrap.
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!valid && req[idx]) begin
        winner = idx_t'(idx);
        valid  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/shared_reg_arbiter.sv
// Arbiter and load sequencer for one shared WIDTH-bit enable register: IDLE -> GRANT -> ACK.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module shared_reg_arbiter
  import shared_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                reset,
  shared_reg_arbiter_if.slave bus
);

  state_t state;
  idx_t   win_q;
  idx_t   pick_winner;
  logic   pick_valid;
`ifndef ARB_FIXED_PRIO_EN
  idx_t   ptr;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
`ifndef ARB_FIXED_PRIO_EN
    .ptr    (ptr),
`endif
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign bus.busy = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      win_q   <= '0;
      bus.gnt <= '0;
      bus.ack <= '0;
      // NOTE: the shared register is a single word of flops, so it is reset like any control register.
      bus.q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr     <= idx_t'(NREQ - 1);
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          bus.ack <= '0;
          if (pick_valid) begin
            bus.gnt <= NREQ'(onehot(pick_winner));
            win_q   <= pick_winner;
`ifndef ARB_FIXED_PRIO_EN
            ptr     <= pick_winner;
`endif
            state   <= ST_GRANT;
          end else begin
            bus.gnt <= '0;
          end
        end
        ST_GRANT: begin
          bus.gnt <= '0;
          // A dropped request abandons the grant: no load, no ack, straight back to IDLE.
          if (bus.req[win_q]) begin
            bus.q   <= bus.data_in[int'(win_q)*WIDTH +: WIDTH];
            bus.ack <= NREQ'(onehot(win_q));
            state   <= ST_ACK;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_ACK: begin
          bus.ack <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          bus.gnt <= '0;
          bus.ack <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
